sum_feed_tx: RTL and testbench

Transmit side of the serial-sum link. Buffers signed samples written by an upstream producer, then on command emits one frame to the serial accumulator: a count N, then N samples on consecutive cycles. It drives the accumulator's enable, count and data inputs, and sits between the sample source and the accumulator in the datapath.

---
 rtl/sum_pkg.sv | 12 +
 rtl/sum_feed_tx_if.sv | 9 +
 rtl/sum_fifo.sv | 48 ++++
 rtl/sum_feed_tx.sv | 123 ++++++++++++
 tb/tb_sum_feed_tx.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/sum_pkg.sv
// Shared definitions for the serial-sum link (transmitter and accumulator).
package sum_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/sum_feed_tx_if.sv
// Producer -> transmitter sample write channel (valid/ready).
interface sum_feed_tx_if #(parameter int DATA_W = 8);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/sum_fifo.sv
// Circular sample buffer; push and pop in the same cycle are both honoured.
module sum_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH+1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [LW-1:0] r_level;

  assign dout_o  = r_mem[r_rp];
  assign full_o  = (r_level == LW'(DEPTH));
  assign empty_o = (r_level == '0);
  assign level_o = r_level;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wp] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (push_i) r_wp <= r_wp + AW'(1);
      if (pop_i)  r_rp <= r_rp + AW'(1);
      case ({push_i, pop_i})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/sum_feed_tx.sv
// Frame transmitter: buffers samples, then emits LOAD, N samples, DONE
// to the serial accumulator. All accumulator-facing outputs are registered.
module sum_feed_tx
  import sum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = $clog2(DEPTH+1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  sum_feed_tx_if.slave      wr,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_i,
  output logic              busy_o,
  output logic              en_o,
  output logic [CNT_W-1:0]  n_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              done_o,
  output logic              err_o,
  output logic [LVL_W-1:0]  level_o
);
  state_t            r_state;
  logic [CNT_W-1:0]  r_n, r_rem;
  logic              r_en, r_last, r_done, r_err, r_busy;
  logic [DATA_W-1:0] r_data;

  logic              w_push, w_pop, w_full, w_empty, w_start_ok;
  logic [DATA_W-1:0] w_head;
  logic [LVL_W-1:0]  w_level;

  assign w_push      = wr.wr_valid & ~w_full;
  assign wr.wr_ready = ~w_full;

  // Pop as each sample is captured into data_o: at the end of LOAD and at
  // the end of every STREAM cycle except the last one.
  assign w_pop = ~w_empty & ((r_state == LOAD) ||
                             (r_state == STREAM && r_rem != CNT_W'(1)));

  // Only buffered samples may be framed, which also bounds N by DEPTH.
  assign w_start_ok = (n_i != '0) && (n_i <= CNT_W'(w_level));

  sum_fifo #(.DW(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .din_i   (wr.wr_data),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

  // Frame FSM with registered outputs; r_rem counts samples still on the wire
  // including the one currently presented.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_rem   <= '0;
      r_en    <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            if (w_start_ok) begin
              r_state <= LOAD;
              r_n     <= n_i;
              r_en    <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          r_state <= STREAM;
          r_rem   <= r_n;
          r_data  <= w_head;
          r_last  <= (r_n == CNT_W'(1));
        end
        STREAM: begin
          if (r_rem == CNT_W'(1)) begin
            r_state <= DONE;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_rem  <= r_rem - CNT_W'(1);
            r_data <= w_head;
            r_last <= (r_rem == CNT_W'(2));
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_en    <= 1'b0;
          r_n     <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o  = r_busy;
  assign en_o    = r_en;
  assign n_o     = r_n;
  assign data_o  = r_data;
  assign last_o  = r_last;
  assign done_o  = r_done;
  assign err_o   = r_err;
  assign level_o = w_level;
endmodule

// File: tb/tb_sum_feed_tx.sv
// Bench for sum_feed_tx: a frame-timeline reference model checks every cycle,
// plus a vector table and hand sequences for full, reset and start-ignore cases.
module tb_sum_feed_tx;
  localparam int DW = 8, CW = 8, DEPTH = 16, LW = 5;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  sum_feed_tx_if #(.DATA_W(DW)) wr_if ();
  logic                 start;
  logic [CW-1:0]        n_in;
  logic                 busy_o, en_o, last_o, done_o, err_o;
  logic [CW-1:0]        n_o;
  logic signed [DW-1:0] data_o;
  logic [LW-1:0]        level_o;

  sum_feed_tx #(.DATA_W(DW), .CNT_W(CW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .wr(wr_if.slave), .start_i(start), .n_i(n_in),
    .busy_o(busy_o), .en_o(en_o), .n_o(n_o), .data_o(data_o), .last_o(last_o),
    .done_o(done_o), .err_o(err_o), .level_o(level_o)
  );

  // Expected output of one cycle, as a timeline entry.
  typedef struct packed {
    logic en; logic [CW-1:0] n; logic [DW-1:0] data;
    logic last, done, err, busy, pop;
  } rec_t;

  rec_t                 cur;
  rec_t                 sched[$];
  logic signed [DW-1:0] q[$];
  int                   exp_sum_q[$];
  int  n_cmp = 0, n_bad = 0;
  int  acc = 0, last_sum = 0, lvl_at_done = 0;
  bit  err_seen = 0, done_seen = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: drive inputs, advance model across the edge, compare after it.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit s, input logic [CW-1:0] n);
    rec_t nxt, r;
    bit   wr_ok;
    int   sum;
    wr_if.wr_valid = v; wr_if.wr_data = d; start = s; n_in = n;
    @(posedge clk);
    wr_ok = v && (q.size() < DEPTH);
    nxt   = '0;
    if (sched.size() > 0) begin
      nxt = sched.pop_front();
    end else if (!cur.en && s) begin
      if (n >= 1 && int'(n) <= q.size()) begin
        sum = 0;
        for (int k = 0; k < int'(n); k++) sum += int'(q[k]);
        exp_sum_q.push_back(sum);
        r = '0; r.en = 1; r.n = n; r.busy = 1;
        sched.push_back(r);
        for (int k = 0; k < int'(n); k++) begin
          r = '0; r.en = 1; r.n = n; r.busy = 1; r.pop = 1; r.last = (k == int'(n) - 1);
          sched.push_back(r);
        end
        r = '0; r.en = 1; r.n = n; r.done = 1;
        sched.push_back(r);
        nxt = sched.pop_front();
      end else begin
        nxt.err = 1;
      end
    end
    if (nxt.pop) nxt.data = q.pop_front();
    if (wr_ok) q.push_back(d);
    cur = nxt;
    #1;
    check("cycle_outputs",
          {busy_o, en_o, n_o, data_o, last_o, done_o, err_o, wr_if.wr_ready, level_o},
          {cur.busy, cur.en, cur.n, cur.data, cur.last, cur.done, cur.err,
           q.size() < DEPTH, LW'(q.size())});
    if (err_o) err_seen = 1;
    if (en_o) acc += int'(data_o);
    if (done_o) begin
      done_seen   = 1;
      lvl_at_done = int'(level_o);
      last_sum    = acc;
      if (exp_sum_q.size() == 0) check("sum_unexpected_done", 64'(acc), 64'hDEAD);
      else                       check("frame_sum", 64'(acc), 64'(exp_sum_q.pop_front()));
      acc = 0;
    end
  endtask

  task automatic idle_cyc();
    cyc(0, '0, 0, '0);
  endtask

  task automatic run_until_done(input int maxc);
    done_seen = 0;
    for (int i = 0; i < maxc && !done_seen; i++) idle_cyc();
    check("done_within_budget", 64'(done_seen), 64'd1);
  endtask

  // Reset asserted mid-cycle: outputs must clear before the next edge.
  task automatic do_reset();
    rst = 1;
    #1;
    check("reset_outputs",
          {busy_o, en_o, n_o, data_o, last_o, done_o, err_o, wr_if.wr_ready, level_o},
          {1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0});
    q.delete(); sched.delete(); exp_sum_q.delete();
    cur = '0; acc = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  typedef struct {
    int nwr; int s[4]; logic [CW-1:0] n; bit exp_err; int exp_sum;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{3, '{5, -2, 7, 0},       8'd3, 1'b0, 10};
    tbl[1] = '{2, '{1, 2, 0, 0},        8'd3, 1'b1, 0};
    tbl[2] = '{0, '{0, 0, 0, 0},        8'd0, 1'b1, 0};
    tbl[3] = '{0, '{0, 0, 0, 0},        8'd2, 1'b0, 3};
    tbl[4] = '{4, '{100, 100, -1, -128}, 8'd4, 1'b0, 71};
    tbl[5] = '{1, '{-1, 0, 0, 0},       8'd1, 1'b0, -1};

    wr_if.wr_valid = 0; wr_if.wr_data = '0; start = 0; n_in = '0;
    do_reset();

    // Table: write samples, request a frame, check error/sum outcome.
    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < tbl[i].nwr; w++) cyc(1, DW'(tbl[i].s[w]), 0, '0);
      err_seen = 0;
      cyc(0, '0, 1, tbl[i].n);
      idle_cyc();
      check("tbl_err", 64'(err_seen), 64'(tbl[i].exp_err));
      if (!tbl[i].exp_err) begin
        run_until_done(int'(tbl[i].n) + 4);
        check("tbl_sum", 64'(last_sum), 64'(tbl[i].exp_sum));
        check("tbl_level_at_done", 64'(lvl_at_done), 64'd0);
      end
    end

    // Full buffer: 17th write dropped, then a maximal frame of -128.
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'h80, 0, '0);
    check("full_wr_ready", 64'(wr_if.wr_ready), 64'd0);
    cyc(1, 8'h05, 0, '0);
    check("full_level", 64'(level_o), 64'd16);
    cyc(0, '0, 1, 8'd16);
    run_until_done(24);
    check("full_sum", 64'(last_sum), 64'(-2048));
    check("full_level_at_done", 64'(lvl_at_done), 64'd0);
    idle_cyc();

    // Stream while the producer writes every cycle, then send the new samples.
    for (int i = 0; i < 4; i++) cyc(1, DW'($urandom), 0, '0);
    cyc(1, DW'($urandom), 1, 8'd4);
    for (int i = 0; i < 8; i++) cyc(1, DW'($urandom), 0, '0);
    cyc(0, '0, 1, 8'd4);
    run_until_done(10);
    idle_cyc();

    // Reset mid-STREAM, then a single-sample frame.
    for (int i = 0; i < 3; i++) cyc(1, DW'($urandom), 0, '0);
    cyc(0, '0, 1, 8'd3);
    idle_cyc();
    do_reset();
    cyc(1, 8'h3C, 0, '0);
    cyc(0, '0, 1, 8'd1);
    idle_cyc();
    check("post_reset_data", 64'(data_o), 64'h3C);
    run_until_done(4);
    idle_cyc();

    // start_i during STREAM and DONE is ignored; first IDLE cycle accepts it.
    for (int i = 0; i < 3; i++) cyc(1, DW'($urandom), 0, '0);
    err_seen = 0;
    cyc(0, '0, 1, 8'd2);
    done_seen = 0;
    for (int i = 0; i < 8 && !done_seen; i++) cyc(0, '0, 1, 8'd1);
    check("ignore_done_reached", 64'(done_seen), 64'd1);
    cyc(0, '0, 1, 8'd1);
    check("ignore_in_done", 64'(busy_o), 64'd0);
    cyc(0, '0, 1, 8'd1);
    check("accept_first_idle", 64'(busy_o), 64'd1);
    check("ignore_no_err", 64'(err_seen), 64'd0);
    run_until_done(6);
    idle_cyc();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 4) == 0,
          CW'($urandom_range(0, 6)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
